// File: rtl/audio_rec_pkg.sv
// Shared types and helpers for the audio sample recorder.
package audio_rec_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned MAG_W          = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE,
    DUMP
  } rec_state_e;

  // Magnitude of a sign-extended sample; wide enough that the most negative sample is exact.
  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] x);
    return x[MAG_W-1] ? MAG_W'(-x) : MAG_W'(x);
  endfunction

endpackage

// File: rtl/audio_rec_if.sv
// Valid/ready sample stream (dstream) with end-of-window marker.
interface audio_rec_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/rec_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when not enabled.
module rec_sdp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_sample_recorder.sv
// Captures a triggered window of samples into RAM and replays it as a stream on request.
module audio_sample_recorder
  import audio_rec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              dump,
  input  logic [DATA_W-1:0] threshold,
  audio_rec_if.slave        audio_input,
  audio_rec_if.master       rec_output,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       count
);

  localparam int unsigned CW = AW + 1;

  rec_state_e        state, state_next;
  logic [CW-1:0]     count_next;
  logic              wr_en, trig, in_xfer, dump_go;
  logic [AW-1:0]     wr_addr;

  logic              o_valid, o_last, s_valid, s_last, r_valid, r_last;
  logic [DATA_W-1:0] o_data, s_data, ram_rdata;
  logic [CW-1:0]     rd_ptr;
  logic              pop, o_load, r_take, rd_en;
  logic [AW-1:0]     rd_addr;
  logic              unused_last;

  assign audio_input.ready = 1'b1;
  assign in_xfer           = audio_input.valid;
  assign unused_last       = audio_input.last;
  assign trig = abs_mag(MAG_W'(signed'(audio_input.data))) >= MAG_W'(threshold);

  assign rec_output.data  = o_data;
  assign rec_output.valid = o_valid;
  assign rec_output.last  = o_last;

  // Control FSM, capture writes and count update
  always_comb begin
    state_next = state;
    count_next = count;
    wr_en      = 1'b0;
    wr_addr    = count[AW-1:0];
    dump_go    = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_next = ARMED;
        count_next = '0;
      end
      ARMED: if (in_xfer && trig) begin
        wr_en      = 1'b1;
        wr_addr    = '0;
        count_next = CW'(1);
        state_next = CAPTURE;
      end
      CAPTURE: if (in_xfer) begin
        wr_en      = 1'b1;
        count_next = count + CW'(1);
        if (count == CW'(DEPTH - 1)) state_next = DONE;
      end
      DONE: if (dump) begin
        state_next = DUMP;
        dump_go    = 1'b1;
      end
      DUMP: if (pop && o_last) state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      count_next = count;
      wr_en      = 1'b0;
      dump_go    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Replay flow: RAM stage (r) feeds output register (o) with a one-entry skid (s) behind it
  always_comb begin
    pop     = o_valid && rec_output.ready;
    o_load  = !o_valid || pop;
    r_take  = r_valid && !(s_valid && !o_load);
    rd_en   = dump_go || (state == DUMP && !rd_ptr[AW] && (!r_valid || r_take));
    rd_addr = dump_go ? '0 : rd_ptr[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      rd_ptr  <= '0;
    end else if (abort) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      s_valid <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (o_load) begin
        if (s_valid) begin
          o_valid <= 1'b1;
          o_data  <= s_data;
          o_last  <= s_last;
        end else if (r_valid) begin
          o_valid <= 1'b1;
          o_data  <= ram_rdata;
          o_last  <= r_last;
        end else begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end
      if (s_valid && o_load) begin
        s_valid <= r_valid;
        s_data  <= ram_rdata;
        s_last  <= r_last;
      end else if (!s_valid && !o_load && r_valid) begin
        s_valid <= 1'b1;
        s_data  <= ram_rdata;
        s_last  <= r_last;
      end
      if (rd_en) begin
        r_valid <= 1'b1;
        r_last  <= (rd_addr == AW'(DEPTH - 1));
      end else if (r_take) begin
        r_valid <= 1'b0;
      end
      if (dump_go)    rd_ptr <= CW'(1);
      else if (rd_en) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  rec_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (audio_input.data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_audio_sample_recorder.sv
// Directed + randomized bench for audio_sample_recorder against a queue-based capture model.
module tb_audio_sample_recorder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset, start, abort, dump;
  logic [15:0] threshold;
  logic        busy, done;
  logic [8:0]  count;

  audio_rec_if #(.DATA_W(16)) in_if ();
  audio_rec_if #(.DATA_W(16)) out_if ();

  audio_sample_recorder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .dump        (dump),
    .threshold   (threshold),
    .audio_input (in_if),
    .rec_output  (out_if),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: 0 idle, 1 armed, 2 capturing, 3 full, 4 replaying
  int          m_mode  = 0;
  int          m_count = 0;
  logic [15:0] m_buf[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mag(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_busy"}, 32'(busy), 32'(m_mode != 0));
    chk({tag, "_done"}, 32'(done), 32'(m_mode == 3));
  endtask

  task automatic feed(input logic [15:0] x, input int gap);
    in_if.data  = x;
    in_if.valid = 1'b1;
    tick();
    in_if.valid = 1'b0;
    if (m_mode == 1 && mag(x) >= int'(threshold)) begin
      m_buf.delete();
      m_buf.push_back(x);
      m_count = 1;
      m_mode  = 2;
    end else if (m_mode == 2) begin
      m_buf.push_back(x);
      m_count++;
      if (m_count == DEPTH) m_mode = 3;
    end
    check_status("feed");
    repeat (gap) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (m_mode == 0) begin
      m_mode  = 1;
      m_count = 0;
    end
    check_status("start");
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_mode = 0;
    check_status("abort");
    chk("abort_valid", 32'(out_if.valid), 32'(0));
  endtask

  task automatic dump_ignored(input string tag);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_novalid"}, 32'(out_if.valid), 32'(0));
      tick();
    end
    check_status(tag);
  endtask

  function automatic logic pick_ready(input int rmode, input int cyc);
    case (rmode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return $urandom_range(0, 2) != 0;
    endcase
  endfunction

  // rmode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic dump_replay(input int rmode);
    int          k, cyc, first;
    bit          stalled;
    logic [15:0] pd;
    logic        pl, rdy;
    out_if.ready = 1'b1;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    m_mode = 4;
    check_status("dump");
    k = 0; cyc = 0; first = -1; stalled = 0; pd = '0; pl = 1'b0;
    while (k < DEPTH && cyc < 4000) begin
      if (stalled) begin
        chk("hold_valid", 32'(out_if.valid), 32'(1));
        chk("hold_data", 32'(out_if.data), 32'(pd));
        chk("hold_last", 32'(out_if.last), 32'(pl));
      end
      rdy = pick_ready(rmode, cyc);
      out_if.ready = rdy;
      if (out_if.valid) begin
        if (first < 0) first = cyc;
        if (rdy) begin
          chk("beat_data", 32'(out_if.data), 32'(m_buf[k]));
          chk("beat_last", 32'(out_if.last), 32'(k == DEPTH - 1));
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = out_if.data;
          pl = out_if.last;
        end
      end
      tick();
      cyc++;
    end
    chk("replay_beats", 32'(k), 32'(DEPTH));
    chk("first_valid_cycle", 32'(first), 32'(1));
    if (rmode == 0) chk("contiguous_cycles", 32'(cyc), 32'(DEPTH + 1));
    m_mode = 3;
    chk("after_last_valid", 32'(out_if.valid), 32'(0));
    check_status("replay_end");
    out_if.ready = 1'b1;
  endtask

  task automatic fill_random(input int gap);
    for (int i = 0; i < 4 * DEPTH && m_mode != 3; i++) feed(16'($urandom), gap);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; dump = 1'b0; threshold = '0;
    in_if.data = '0; in_if.valid = 1'b0; in_if.last = 1'b0;
    out_if.ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(out_if.valid), 32'(0));
    chk("rst_last", 32'(out_if.last), 32'(0));
    chk("rst_data", 32'(out_if.data), 32'(0));
    chk("rst_ready", 32'(in_if.ready), 32'(1));
    check_status("rst");
    reset = 1'b0;
    tick();

    // Immediate trigger, ramp capture, full-rate replay then stalled replay of the same buffer
    threshold = 16'd0;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) feed(16'(i), 0);
    dump_replay(0);
    dump_replay(1);

    // Amplitude trigger at exactly the threshold magnitude
    pulse_abort();
    threshold = 16'd1000;
    pulse_start();
    feed(16'(5), 0);
    feed(16'(-999), 0);
    chk("t2_armed_count", 32'(count), 32'(0));
    feed(16'(-1000), 1);
    feed(16'(7), 0);
    fill_random(0);
    dump_replay(2);

    // Abort mid-capture keeps count; dump outside DONE ignored; idle input dropped
    pulse_abort();
    threshold = 16'd0;
    pulse_start();
    for (int i = 0; i < 100; i++) feed(16'($urandom), 0);
    pulse_abort();
    chk("t4_count", 32'(count), 32'(100));
    for (int i = 0; i < 3; i++) feed(16'($urandom), 0);
    dump_ignored("t4_dump");

    // Start during capture and dump while armed are ignored
    pulse_start();
    for (int i = 0; i < 10; i++) feed(16'($urandom), 0);
    pulse_start();
    feed(16'($urandom), 0);
    chk("t5_count", 32'(count), 32'(11));
    pulse_abort();
    threshold = 16'hFFFF;
    pulse_start();
    for (int i = 0; i < 5; i++) feed(16'($urandom), 0);
    dump_ignored("t5_dump_armed");
    threshold = 16'd0;
    fill_random(0);
    dump = 1'b1;
    tick();
    dump = 1'b0;
    repeat (5) tick();
    chk("t5_mid_dump_valid", 32'(out_if.valid), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_mode = 0;
    m_count = 0;
    chk("t5_rst_valid", 32'(out_if.valid), 32'(0));
    chk("t5_rst_last", 32'(out_if.last), 32'(0));
    chk("t5_rst_data", 32'(out_if.data), 32'(0));
    chk("t5_rst_ready", 32'(in_if.ready), 32'(1));
    check_status("t5_rst");
    repeat (3) tick();
    chk("t5_post_rst_valid", 32'(out_if.valid), 32'(0));

    // Most negative sample triggers at max threshold; sparse input stored without gaps
    threshold = 16'h7FFF;
    pulse_start();
    for (int i = 0; i < 6; i++) feed(16'($urandom_range(0, 2000) - 1000), 2);
    feed(16'h8000, 2);
    chk("t6_trig_count", 32'(count), 32'(1));
    fill_random(2);
    dump_replay(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
